vedic_mac_acc: RTL and testbench
================================

# vedic_mac_acc

Sequential multiply-accumulate stage built around the combinational `vedic_16x16` multiplier. It accepts a programmed number of 16-bit operand pairs over a valid/ready stream. It registers each 32-bit product and sums the products into a wide accumulator. It then presents the dot-product result on a valid/ready output port. It is the consumer of the multiplier's 32-bit product and feeds downstream filter and transform logic.

## Interface
- `ACC_W`, default 40: accumulator and result width. Legal range 33..64.
- `LEN_W`, default 8: width of the term-count input.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a new accumulation. Sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs to accumulate. Captured with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair this cycle.
- `in_a`  in  16  multiplicand, unsigned.
- `in_b`  in  16  multiplier, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_acc`  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- `out_ovf`  out  1  sticky flag: a carry left bit ACC_W-1 during this accumulation.

## Operation
- FSM states: IDLE, ACC, DRAIN, DONE.
- IDLE → ACC on `start`:
  - load `remaining` from `len`;
  - clear the accumulator and the overflow flag;
  - clear the product-valid flag (`p_vld`).
- `start` while `busy` is ignored.
- `start` with `len`=0: IDLE → DONE. The result is 0 with `out_ovf`=0.
- In ACC, `in_ready`=1 when `remaining`≠0.
- A transfer happens when `in_valid && in_ready`. On that edge:
  - `p_q` ← `vedic_16x16(in_a, in_b)`;
  - `p_vld` ← 1;
  - `remaining` is decremented.
- With no transfer, `p_vld` ← 0.
- Whenever `p_vld`=1: `acc` ← `acc` + zero-extend(`p_q`), truncated to ACC_W. `ovf` |= the carry out of the add.
- ACC → DRAIN on the edge that accepts the last pair (`remaining` goes 1→0).
- DRAIN → DONE on the next edge, after the final product has been added.
- In DONE:
  - `out_valid`=1; `out_acc` and `out_ovf` are held stable.
  - DONE → IDLE on `out_valid && out_ready`.
  - `start` in the same cycle is ignored; it takes effect one cycle later in IDLE.
- Arithmetic is fully unsigned. Products are 32 bits and are zero-extended to ACC_W. The accumulator wraps on overflow and does not saturate.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0. All internal registers are 0 and the state is IDLE.
- `rst` mid-operation aborts on that edge. No partial result is output, and in-flight products are discarded.
- Latency: the last pair is accepted at edge k, added into the accumulator at edge k+1, and `out_valid` is high in the cycle after edge k+1.
- With `len`=0, `out_valid` is high in the cycle after the `start` edge.
- Throughput: one pair per cycle while `in_valid` stays high.
- The critical path is the combinational `vedic_16x16` into `p_q`. Nothing else sits on that path.
- `in_ready` is a registered-state decode. It does not depend combinationally on `in_valid` or `out_ready`.

## Structure
- Shared package holds:
  - the state enumeration (IDLE/ACC/DRAIN/DONE);
  - the 16-bit operand width constant;
  - the 32-bit product width constant.
- Sub-module: one instance of the existing `vedic_16x16` (a, b → c[31:0]), used unmodified.
- The FSM, counter, product register and accumulator live in `vedic_mac_acc`. There are no further sub-modules.

## Test plan
- **Single term.** `len`=1, a=0xFFFF, b=0xFFFF → `out_acc`=0xFFFE0001, `out_ovf`=0. `out_valid` is high exactly 2 edges after acceptance.
- **Three terms with gaps.** `len`=3, pairs (3,5), (7,11), (0x0100,0x0100), with `in_valid` gaps of 0, 2 and 1 cycles → `out_acc`=0x1005C. `in_ready` drops after the third accept.
- **Zero length and overflow.**
  - `len`=0 → `out_valid` after 1 edge, `out_acc`=0.
  - Then ACC_W=33, `len`=3, three pairs (0xFFFF,0xFFFF) → `out_acc`=0x0FFFA0003, `out_ovf`=1.
- **Output backpressure.** Hold `out_ready`=0 for 5 cycles in DONE → `out_acc` is stable. Pulse `start` during the hold → it is ignored. After release, `busy` falls on the next edge.
- **Reset mid-run.** `len`=4; assert `rst` after 2 accepts → all outputs are 0 on the next cycle. A fresh `len`=1 run with (2,3) then yields 6, with no residue from the aborted run.

Source files
------------

// File: rtl/vedic_mac_acc_pkg.sv
// Shared definitions for the Vedic multiply-accumulate stage.
package vedic_mac_acc_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/vedic_16x16.sv
// Combinational 16x16 unsigned multiplier built from the Urdhva Tiryagbhyam
// (vertical and crosswise) scheme: 2x2 cells composed into 4x4, 8x8 and 16x16.
module vedic_16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] c
);

    function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] r;
        logic       p00, p01, p10, p11, c1;
        p00  = x[0] & y[0];
        p10  = x[1] & y[0];
        p01  = x[0] & y[1];
        p11  = x[1] & y[1];
        c1   = p10 & p01;
        r[0] = p00;
        r[1] = p10 ^ p01;
        r[2] = p11 ^ c1;
        r[3] = p11 & c1;
        return r;
    endfunction

    function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = v2(x[1:0], y[1:0]);
        q1 = v2(x[3:2], y[1:0]);
        q2 = v2(x[1:0], y[3:2]);
        q3 = v2(x[3:2], y[3:2]);
        return {q3, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00};
    endfunction

    function automatic logic [15:0] v8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] q0, q1, q2, q3;
        q0 = v4(x[3:0], y[3:0]);
        q1 = v4(x[7:4], y[3:0]);
        q2 = v4(x[3:0], y[7:4]);
        q3 = v4(x[7:4], y[7:4]);
        return {q3, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0};
    endfunction

    // Combine the four 8x8 partial products into the full 32-bit product.
    always_comb begin
        logic [15:0] q0, q1, q2, q3;
        q0 = v8(a[7:0],  b[7:0]);
        q1 = v8(a[15:8], b[7:0]);
        q2 = v8(a[7:0],  b[15:8]);
        q3 = v8(a[15:8], b[15:8]);
        c  = {q3, q0} + {8'h00, q1, 8'h00} + {8'h00, q2, 8'h00};
    end

endmodule

// File: rtl/vedic_mac_acc.sv
// Sequential multiply-accumulate: streams a programmed number of 16-bit
// operand pairs through vedic_16x16, registers each product and sums the
// products into a wide wrapping accumulator with a sticky overflow flag.
module vedic_mac_acc
    import vedic_mac_acc_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    state_e             state_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [PROD_W-1:0]  p_q;
    logic               p_vld_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum;
    logic               xfer;

    // The multiplier feeds p_q directly; nothing else sits between them.
    vedic_16x16 u_mult (
        .a (in_a),
        .b (in_b),
        .c (prod)
    );

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_ACC) && (remaining_q != '0);
    assign out_valid = (state_q == ST_DONE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign xfer      = in_valid && in_ready;

    // Add the pending product one cycle after it was captured; the extra top bit catches the carry.
    always_comb begin
        sum   = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_q};
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (p_vld_q) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    // Control FSM, term counter, product register and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            p_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= len;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        p_vld_q     <= 1'b0;
                        state_q     <= (len == '0) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (xfer) begin
                        p_q         <= prod;
                        p_vld_q     <= 1'b1;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Testbench for vedic_mac_acc: two instances (ACC_W=40 and ACC_W=33) share
// one stimulus stream; results are compared against a plain-arithmetic
// dot-product model and a table of directed vectors.
module tb_vedic_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_ready;

    logic        busy40, inReady40, outValid40, outOvf40;
    logic [39:0] outAcc40;
    logic        busy33, inReady33, outValid33, outOvf33;
    logic [32:0] outAcc33;

    int checks = 0;
    int errors = 0;

    logic [15:0] jobA[0:31];
    logic [15:0] jobB[0:31];
    int          jobGap[0:31];

    typedef struct {
        int               n;
        int               hold;
        logic [0:3][15:0] a;
        logic [0:3][15:0] b;
        logic [0:3][3:0]  gap;
        logic [39:0]      e40;
        logic             o40;
        logic [32:0]      e33;
        logic             o33;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    vedic_mac_acc #(.ACC_W(40), .LEN_W(8)) dut40 (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy40),
        .in_valid(in_valid), .in_ready(inReady40), .in_a(in_a), .in_b(in_b),
        .out_valid(outValid40), .out_ready(out_ready), .out_acc(outAcc40), .out_ovf(outOvf40)
    );

    vedic_mac_acc #(.ACC_W(33), .LEN_W(8)) dut33 (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy33),
        .in_valid(in_valid), .in_ready(inReady33), .in_a(in_a), .in_b(in_b),
        .out_valid(outValid33), .out_ready(out_ready), .out_acc(outAcc33), .out_ovf(outOvf33)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: the true dot product, reduced modulo 2^W; overflow iff the true sum reaches 2^W.
    task automatic model(input int n, output logic [39:0] e40, output logic o40,
                         output logic [32:0] e33, output logic o33);
        logic [63:0] total;
        total = 64'd0;
        for (int i = 0; i < n; i++) begin
            total = total + 64'(jobA[i]) * 64'(jobB[i]);
        end
        e40 = total[39:0];
        o40 = (total >= (64'd1 << 40));
        e33 = total[32:0];
        o33 = (total >= (64'd1 << 33));
    endtask

    task automatic applyStimulus(input int n, input int hold,
                                 input logic [39:0] e40, input logic o40,
                                 input logic [32:0] e33, input logic o33);
        logic accepted;
        int   waitCnt;
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'd0;
        checkOutput("busy_after_start", 64'(busy40), 64'd1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            for (int g = 0; g < jobGap[i]; g++) tick();
            in_valid = 1'b1;
            in_a     = jobA[i];
            in_b     = jobB[i];
            accepted = 1'b0;
            waitCnt  = 0;
            while (!accepted && waitCnt < 16) begin
                accepted = inReady40;
                tick();
                waitCnt++;
            end
            if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        in_a     = 16'h0;
        in_b     = 16'h0;
        if (n > 0) begin
            checkOutput("ready_after_last", 64'(inReady40), 64'd0);
            checkOutput("valid_before_drain", 64'(outValid40), 64'd0);
            tick();
        end
        checkOutput("valid_latency40", 64'(outValid40), 64'd1);
        checkOutput("valid_latency33", 64'(outValid33), 64'd1);
        waitCnt = 0;
        while (!outValid40 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkOutput("acc40", 64'(outAcc40), 64'(e40));
        checkOutput("ovf40", 64'(outOvf40), 64'(o40));
        checkOutput("acc33", 64'(outAcc33), 64'(e33));
        checkOutput("ovf33", 64'(outOvf33), 64'(o33));
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            len   = 8'd3;
            tick();
            start = 1'b0;
            len   = 8'd0;
            checkOutput("hold_valid", 64'(outValid40), 64'd1);
            checkOutput("hold_acc40", 64'(outAcc40), 64'(e40));
            checkOutput("hold_acc33", 64'(outAcc33), 64'(e33));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("busy_after_release", 64'(busy40), 64'd0);
        checkOutput("valid_after_release", 64'(outValid33), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [39:0] e40;
        logic        o40;
        logic [32:0] e33;
        logic        o33;
        int          n;

        vecs[0] = '{n:1, hold:0, a:{16'hFFFF, 16'h0, 16'h0, 16'h0}, b:{16'hFFFF, 16'h0, 16'h0, 16'h0},
                    gap:{4'd0, 4'd0, 4'd0, 4'd0},
                    e40:40'hFFFE0001, o40:1'b0, e33:33'h0FFFE0001, o33:1'b0};
        vecs[1] = '{n:3, hold:0, a:{16'h3, 16'h7, 16'h0100, 16'h0}, b:{16'h5, 16'hB, 16'h0100, 16'h0},
                    gap:{4'd0, 4'd2, 4'd1, 4'd0},
                    e40:40'h1005C, o40:1'b0, e33:33'h1005C, o33:1'b0};
        vecs[2] = '{n:0, hold:0, a:{16'h0, 16'h0, 16'h0, 16'h0}, b:{16'h0, 16'h0, 16'h0, 16'h0},
                    gap:{4'd0, 4'd0, 4'd0, 4'd0},
                    e40:40'h0, o40:1'b0, e33:33'h0, o33:1'b0};
        vecs[3] = '{n:3, hold:0, a:{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0}, b:{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0},
                    gap:{4'd0, 4'd0, 4'd0, 4'd0},
                    e40:40'h2FFFA0003, o40:1'b0, e33:33'h0FFFA0003, o33:1'b1};
        vecs[4] = '{n:2, hold:5, a:{16'h1234, 16'hFFFF, 16'h0, 16'h0}, b:{16'h0010, 16'h0001, 16'h0, 16'h0},
                    gap:{4'd1, 4'd0, 4'd0, 4'd0},
                    e40:40'h2233F, o40:1'b0, e33:33'h2233F, o33:1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_a      = 16'h0;
        in_b      = 16'h0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_busy", 64'(busy40), 64'd0);
        checkOutput("reset_ready", 64'(inReady40), 64'd0);
        checkOutput("reset_valid", 64'(outValid40), 64'd0);
        checkOutput("reset_acc", 64'(outAcc40), 64'd0);
        checkOutput("reset_ovf", 64'(outOvf33), 64'd0);

        $display("[TB] directed vectors");
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                jobA[i]   = vecs[v].a[i];
                jobB[i]   = vecs[v].b[i];
                jobGap[i] = int'(vecs[v].gap[i]);
            end
            applyStimulus(vecs[v].n, vecs[v].hold, vecs[v].e40, vecs[v].o40, vecs[v].e33, vecs[v].o33);
        end

        $display("[TB] reset mid-run");
        start = 1'b1;
        len   = 8'd4;
        tick();
        start    = 1'b0;
        len      = 8'd0;
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy40), 64'd0);
        checkOutput("abort_ready", 64'(inReady40), 64'd0);
        checkOutput("abort_valid", 64'(outValid40), 64'd0);
        checkOutput("abort_acc40", 64'(outAcc40), 64'd0);
        checkOutput("abort_acc33", 64'(outAcc33), 64'd0);
        checkOutput("abort_ovf", 64'(outOvf40), 64'd0);
        jobA[0]   = 16'd2;
        jobB[0]   = 16'd3;
        jobGap[0] = 0;
        applyStimulus(1, 0, 40'd6, 1'b0, 33'd6, 1'b0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 30; j++) begin
            n = (j == 29) ? 24 : int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) begin
                jobA[i]   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                jobB[i]   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                jobGap[i] = int'($urandom_range(0, 2));
            end
            model(n, e40, o40, e33, o33);
            applyStimulus(n, int'($urandom_range(0, 4)), e40, o40, e33, o33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
